fp_iter_divider: RTL and testbench

- Sequential floating-point mantissa/exponent divider. Computes A / B using the same unsigned {exponent, explicit-leading-one mantissa} operand format as the fused multiply-add path.
- The multiply path produces products; this block is its inverse-direction companion and produces quotients.
- Uses a restoring shift-subtract algorithm: one quotient bit per cycle, with valid/ready handshakes on both the input and output sides.
- Sits alongside the fused multiplier in the arithmetic unit.

---
 rtl/fp_iter_divider.sv | 166 ++++++++++++++++
 tb/tb_fp_iter_divider.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fp_iter_divider.sv
// Sequential {exponent, mantissa} divider: restoring shift-subtract, one quotient bit per cycle.
// Valid/ready handshakes on both sides; result held in DONE until the consumer accepts it.
module fp_iter_divider #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [EXP_W-1:0] expA,
   input  logic [MAN_W-1:0] manA,
   input  logic [EXP_W-1:0] expB,
   input  logic [MAN_W-1:0] manB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [EXP_W-1:0] expQ,
   output logic [MAN_W-1:0] manQ,
   output logic             inexact,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(MAN_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ITER, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [EXP_W-1:0]   expa_q, expa_d, expb_q, expb_d;
   logic [MAN_W-1:0]   mana_q, mana_d, manb_q, manb_d;
   logic [MAN_W:0]     rem_q, rem_d;
   logic [MAN_W-1:0]   quo_q, quo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [EXP_W-1:0]   exp_tmp_q, exp_tmp_d;
   logic [EXP_W-1:0]   expq_q, expq_d;
   logic [MAN_W-1:0]   manq_q, manq_d;
   logic               inexact_q, inexact_d;
   logic               dbz_q, dbz_d;

   logic               accept;
   logic               special;
   logic               rem_ge;
   logic [MAN_W:0]     rem_sub;
   logic [MAN_W-1:0]   quo_shift;
   logic               last_iter;

   assign accept    = in_valid && (state_q == S_IDLE);
   assign special   = (manB == '0) || (manA == '0);
   assign rem_ge    = rem_q >= {1'b0, manb_q};
   assign rem_sub   = rem_ge ? (rem_q - {1'b0, manb_q}) : rem_q;
   assign quo_shift = (quo_q << 1) | MAN_W'(rem_ge);
   assign last_iter = (cnt_q == CNT_W'(MAN_W - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         expa_q    <= '0;
         expb_q    <= '0;
         mana_q    <= '0;
         manb_q    <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         exp_tmp_q <= '0;
         expq_q    <= '0;
         manq_q    <= '0;
         inexact_q <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         expa_q    <= expa_d;
         expb_q    <= expb_d;
         mana_q    <= mana_d;
         manb_q    <= manb_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
         exp_tmp_q <= exp_tmp_d;
         expq_q    <= expq_d;
         manq_q    <= manq_d;
         inexact_q <= inexact_d;
         dbz_q     <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = special ? S_DONE : S_ALIGN;
         S_ALIGN: state_d = S_ITER;
         S_ITER:  if (last_iter) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
   end

   always_comb begin
      expa_d    = expa_q;
      expb_d    = expb_q;
      mana_d    = mana_q;
      manb_d    = manb_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      cnt_d     = cnt_q;
      exp_tmp_d = exp_tmp_q;
      expq_d    = expq_q;
      manq_d    = manq_q;
      inexact_d = inexact_q;
      dbz_d     = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               expa_d = expA;
               expb_d = expB;
               mana_d = manA;
               manb_d = manB;
               if (manB == '0) begin
                  manq_d    = '1;
                  expq_d    = '1;
                  inexact_d = 1'b0;
                  dbz_d     = 1'b1;
               end else if (manA == '0) begin
                  manq_d    = '0;
                  expq_d    = '0;
                  inexact_d = 1'b0;
                  dbz_d     = 1'b0;
               end
            end
         end
         S_ALIGN: begin
            // Pre-shift a smaller dividend so the first quotient bit is always 1.
            if (mana_q >= manb_q) begin
               rem_d     = {1'b0, mana_q};
               exp_tmp_d = expa_q - expb_q;
            end else begin
               rem_d     = {mana_q, 1'b0};
               exp_tmp_d = expa_q - expb_q - EXP_W'(1);
            end
            quo_d = '0;
            cnt_d = '0;
         end
         S_ITER: begin
            rem_d = rem_sub << 1;
            quo_d = quo_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) begin
               manq_d    = quo_shift;
               expq_d    = exp_tmp_q;
               inexact_d = (rem_sub != '0);
               dbz_d     = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign expQ        = expq_q;
   assign manQ        = manq_q;
   assign inexact     = inexact_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_iter_divider.sv
// Directed self-checking bench for fp_iter_divider: quotient values, latency,
// backpressure and mid-division asynchronous reset.
module tb_fp_iter_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  expA = '0, expB = '0;
   logic [23:0] manA = '0, manB = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  expQ;
   logic [23:0] manQ;
   logic        inexact;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   fp_iter_divider #(.EXP_W(8), .MAN_W(24)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .expA(expA), .manA(manA), .expB(expB), .manB(manB),
      .out_valid(out_valid), .out_ready(out_ready),
      .expQ(expQ), .manQ(manQ), .inexact(inexact), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s = %0h", tag, obs);
      end
   endtask

   // Called at #1 after a rising edge with the block idle; returns with out_valid high.
   task automatic run_div(input string tag,
                          input logic [7:0] ea, input logic [23:0] ma,
                          input logic [7:0] eb, input logic [23:0] mb,
                          input logic [7:0] xe, input logic [23:0] xm,
                          input logic xi, input logic xd, input int xlat);
      int n;
      chk({tag, "_rdy"}, in_ready, 1);
      expA = ea; manA = ma; expB = eb; manB = mb;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_lat"}, n, xlat);
      chk({tag, "_man"}, manQ, xm);
      chk({tag, "_exp"}, expQ, xe);
      chk({tag, "_inx"}, inexact, xi);
      chk({tag, "_dbz"}, div_by_zero, xd);
      chk({tag, "_busy"}, in_ready, 0);
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_ovld0"}, out_valid, 0);
      chk({tag, "_irdy1"}, in_ready, 1);
   endtask

   initial begin
      #1;
      chk("rst_irdy", in_ready, 1);
      chk("rst_ovld", out_valid, 0);
      chk("rst_man", manQ, 0);
      chk("rst_exp", expQ, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_div("one", 8'd5, 24'h800000, 8'd3, 24'h800000, 8'd2, 24'h800000, 0, 0, 25);
      release_out("one");

      run_div("dbz", 8'd9, 24'h912345, 8'd4, 24'h000000, 8'hFF, 24'hFFFFFF, 0, 1, 0);
      release_out("dbz");

      run_div("zra", 8'd9, 24'h000000, 8'd4, 24'h800000, 8'h00, 24'h000000, 0, 0, 0);
      release_out("zra");

      run_div("thr", 8'd7, 24'h800000, 8'd2, 24'hC00000, 8'd4, 24'hAAAAAA, 1, 0, 25);
      // Backpressure: result must hold and new operands must be ignored.
      for (int i = 0; i < 10; i++) begin
         expA = 8'd1; manA = 24'h000000; expB = 8'd1; manB = 24'h000000;
         in_valid = 1'b1;
         @(posedge clk); #1;
         if (i == 0 || i == 9) begin
            chk("bp_ovld", out_valid, 1);
            chk("bp_irdy", in_ready, 0);
            chk("bp_man", manQ, 24'hAAAAAA);
            chk("bp_exp", expQ, 8'd4);
         end
      end
      in_valid = 1'b0;
      release_out("bp");
      chk("bp_keep_man", manQ, 24'hAAAAAA);
      chk("bp_keep_dbz", div_by_zero, 0);

      run_div("wrap", 8'd1, 24'hC00000, 8'd3, 24'h800000, 8'hFE, 24'hC00000, 0, 0, 25);
      release_out("wrap");

      run_div("max", 8'd0, 24'hFFFFFF, 8'd0, 24'h800000, 8'd0, 24'hFFFFFF, 0, 0, 25);
      release_out("max");

      // Mid-division reset: accept edge, ALIGN edge, then 12 iteration edges.
      expA = 8'd6; manA = 24'hC00000; expB = 8'd1; manB = 24'h800000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (13) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mrst_irdy", in_ready, 1);
      chk("mrst_ovld", out_valid, 0);
      chk("mrst_man", manQ, 0);
      chk("mrst_exp", expQ, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_div("post", 8'd0, 24'h800000, 8'd0, 24'h800000, 8'd0, 24'h800000, 0, 0, 25);
      release_out("post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end

endmodule
